// File: rtl/cc_bridge_pkg.sv
// Shared types and constants for the CPU-to-cache bridge.
// Holds the cacheability decode used by both channels.
package cc_bridge_pkg;

    localparam int CC_MODE_PORT     = 0;
    localparam int CC_MODE_KSEG     = 1;
    localparam int CC_MODE_UNCACHED = 2;

    localparam logic [2:0] CC_KSEG0_SEG = 3'b100;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        logic        op;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        uncache;
    } cc_req_t;

    function automatic logic cc_uncache(input int mode, input logic cached, input logic [2:0] seg);
        case (mode)
            CC_MODE_PORT: return !cached;
            CC_MODE_KSEG: return seg != CC_KSEG0_SEG;
            default:      return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/cc_bridge_if.sv
// Cache-side bus interfaces driven by the bridge (instruction and data).
interface cpu_ibus_if #(
    parameter int DATA_W = 64
);
    logic              valid;
    logic              op;
    logic [31:0]       addr;
    logic [1:0]        size;
    logic              uncache;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (output valid, op, addr, size, uncache, input addr_ok, data_ok, rdata);
    modport slave  (input valid, op, addr, size, uncache, output addr_ok, data_ok, rdata);
endinterface

interface cpu_dbus_if;
    logic        valid;
    logic        op;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        uncache;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output valid, op, addr, size, wstrb, wdata, uncache, input addr_ok, data_ok, rdata);
    modport slave  (input valid, op, addr, size, wstrb, wdata, uncache, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/cc_bridge_chan.sv
// One bridge channel: request slot, outstanding counter, cached/uncached
// ordering, stale-response detection and optional response register.
module cc_bridge_chan
    import cc_bridge_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RSP_REG         = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  cc_req_t           i_req_d,
    output logic              o_addr_ok,
    output logic              o_data_ok,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_bus_valid,
    output cc_req_t           o_bus_req,
    input  logic              i_bus_addr_ok,
    input  logic              i_bus_data_ok,
    input  logic [DATA_W-1:0] i_bus_rdata,
    output logic              o_proto_err
);
    localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic             r_slot_v;
    cc_req_t          r_slot;
    logic [CNT_W-1:0] r_count;
    logic             r_last_unc;
    logic             r_proto_err;

    logic w_busy;
    logic w_order_block;
    logic w_accept;
    logic w_rsp;
    logic w_stale;

    // addr_ok must not depend on i_req; reset gates it so nothing is granted mid-reset
    always_comb begin
        w_busy        = (r_count != '0);
        w_order_block = w_busy && (i_req_d.uncache != r_last_unc);
        o_addr_ok     = !i_rst && (!r_slot_v || i_bus_addr_ok) && (r_count < CNT_MAX) && !w_order_block;
        w_accept      = i_req && o_addr_ok;
        w_rsp         = i_bus_data_ok && w_busy;
        w_stale       = i_bus_data_ok && !w_busy;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slot_v    <= 1'b0;
            r_slot      <= '0;
            r_count     <= '0;
            r_last_unc  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_slot_v   <= 1'b1;
                r_slot     <= i_req_d;
                r_last_unc <= i_req_d.uncache;
            end else if (i_bus_addr_ok) begin
                r_slot_v <= 1'b0;
            end
            if (w_accept && !w_rsp) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_accept && w_rsp) begin
                r_count <= r_count - CNT_W'(1);
            end
            if (w_stale) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    assign o_bus_valid = r_slot_v;
    assign o_bus_req   = r_slot;
    assign o_proto_err = r_proto_err;

    generate
        if (RSP_REG != 0) begin : g_rsp_reg
            logic              r_rsp_v;
            logic [DATA_W-1:0] r_rsp_data;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_rsp_v    <= 1'b0;
                    r_rsp_data <= '0;
                end else begin
                    r_rsp_v <= w_rsp;
                    if (w_rsp) begin
                        r_rsp_data <= i_bus_rdata;
                    end
                end
            end

            assign o_data_ok = r_rsp_v;
            assign o_rdata   = r_rsp_data;
        end else begin : g_rsp_comb
            assign o_data_ok = w_rsp;
            assign o_rdata   = i_bus_rdata;
        end
    endgenerate

endmodule

// File: rtl/cpu_cache_bridge.sv
// Bridges the core's SRAM-like inst/data ports onto the cache buses;
// decodes cacheability here and leaves all sequencing to two channel instances.
module cpu_cache_bridge
    import cc_bridge_pkg::*;
#(
    parameter int IDATA_W         = 64,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CACHE_MODE      = CC_MODE_PORT,
    parameter int RSP_REG         = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inst_req,
    input  logic [31:0]        inst_addr,
    input  logic [1:0]         inst_size,
    input  logic               inst_cached,
    output logic [IDATA_W-1:0] inst_rdata,
    output logic               inst_addr_ok,
    output logic               inst_data_ok,
    input  logic               data_req,
    input  logic               data_wr,
    input  logic [3:0]         data_wstrb,
    input  logic [31:0]        data_addr,
    input  logic [1:0]         data_size,
    input  logic               data_cached,
    input  logic [31:0]        data_wdata,
    output logic [31:0]        data_rdata,
    output logic               data_addr_ok,
    output logic               data_data_ok,
    cpu_ibus_if.master         ibus,
    cpu_dbus_if.master         dbus,
    output logic               inst_proto_err,
    output logic               data_proto_err
);
    cc_req_t w_inst_req;
    cc_req_t w_data_req;
    cc_req_t w_ibus_req;
    cc_req_t w_dbus_req;
    logic    w_unused_ibus;

    always_comb begin
        w_inst_req         = '0;
        w_inst_req.addr    = inst_addr;
        w_inst_req.size    = inst_size;
        w_inst_req.uncache = cc_uncache(CACHE_MODE, inst_cached, inst_addr[31:29]);

        w_data_req         = '0;
        w_data_req.addr    = data_addr;
        w_data_req.size    = data_size;
        w_data_req.op      = data_wr;
        w_data_req.wstrb   = data_wstrb;
        w_data_req.wdata   = data_wdata;
        w_data_req.uncache = cc_uncache(CACHE_MODE, data_cached, data_addr[31:29]);
    end

    cc_bridge_chan #(
        .DATA_W          (IDATA_W),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .RSP_REG         (RSP_REG)
    ) u_inst_chan (
        .i_clk         (clk),
        .i_rst         (reset),
        .i_req         (inst_req),
        .i_req_d       (w_inst_req),
        .o_addr_ok     (inst_addr_ok),
        .o_data_ok     (inst_data_ok),
        .o_rdata       (inst_rdata),
        .o_bus_valid   (ibus.valid),
        .o_bus_req     (w_ibus_req),
        .i_bus_addr_ok (ibus.addr_ok),
        .i_bus_data_ok (ibus.data_ok),
        .i_bus_rdata   (ibus.rdata),
        .o_proto_err   (inst_proto_err)
    );

    cc_bridge_chan #(
        .DATA_W          (32),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .RSP_REG         (RSP_REG)
    ) u_data_chan (
        .i_clk         (clk),
        .i_rst         (reset),
        .i_req         (data_req),
        .i_req_d       (w_data_req),
        .o_addr_ok     (data_addr_ok),
        .o_data_ok     (data_data_ok),
        .o_rdata       (data_rdata),
        .o_bus_valid   (dbus.valid),
        .o_bus_req     (w_dbus_req),
        .i_bus_addr_ok (dbus.addr_ok),
        .i_bus_data_ok (dbus.data_ok),
        .i_bus_rdata   (dbus.rdata),
        .o_proto_err   (data_proto_err)
    );

    // Instruction fetches carry no write payload on the bus
    assign ibus.op       = 1'b0;
    assign ibus.addr     = w_ibus_req.addr;
    assign ibus.size     = w_ibus_req.size;
    assign ibus.uncache  = w_ibus_req.uncache;
    assign w_unused_ibus = ^{w_ibus_req.op, w_ibus_req.wstrb, w_ibus_req.wdata};

    assign dbus.op      = w_dbus_req.op;
    assign dbus.addr    = w_dbus_req.addr;
    assign dbus.size    = w_dbus_req.size;
    assign dbus.wstrb   = w_dbus_req.wstrb;
    assign dbus.wdata   = w_dbus_req.wdata;
    assign dbus.uncache = w_dbus_req.uncache;

endmodule

// File: doc/cpu_cache_bridge.md
Name: cpu_cache_bridge

Overview:
Parametrised successor to the CPU-to-cache bus convertor. It sits between the core's SRAM-like inst/data request ports and the cache-side cpu_ibus_if/cpu_dbus_if masters. Per channel it adds:
- a registered request slot, which breaks the CPU-to-cache valid path;
- an outstanding-request counter with a programmable cap;
- cached/uncached ordering enforcement;
- a selectable cacheability source;
- an optional registered response stage;
- sticky protocol-error detection.

Parameters:
IDATA_W, 64, inst read-data width (32 or 64)
MAX_OUTSTANDING, 4, max requests in flight per channel (1..15)
CACHE_MODE, 0, 0 = use *_cached port; 1 = cached iff addr[31:29]==3'b100; 2 = force all uncached
RSP_REG, 0, 1 = register rdata/data_ok by one cycle toward the CPU

Ports:
clk  in  1  core clock
reset  in  1  asynchronous active-high reset
inst_req  in  1  inst request
inst_addr  in  32  inst address
inst_size  in  2  inst size
inst_cached  in  1  inst cacheable (CACHE_MODE 0 only)
inst_rdata  out  IDATA_W  inst read data
inst_addr_ok  out  1  inst request accepted
inst_data_ok  out  1  inst response valid
data_req  in  1  data request
data_wr  in  1  1 = write
data_wstrb  in  4  write byte strobes
data_addr  in  32  data address
data_size  in  2  data size
data_cached  in  1  data cacheable (CACHE_MODE 0 only)
data_wdata  in  32  write data
data_rdata  out  32  read data
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response valid
ibus  cpu_ibus_if.master  -  cache inst bus; op tied 0
dbus  cpu_dbus_if.master  -  cache data bus
inst_proto_err  out  1  sticky: inst data_ok with nothing outstanding
data_proto_err  out  1  sticky: data data_ok with nothing outstanding

Behaviour:
- Channels are independent and identical; the inst channel has op=0, wstrb=0 and wdata=0.
- Reset state: slot empty, count=0, last_uncache=0, proto_err=0, response register cleared. All bus valid, addr_ok and data_ok outputs read 0 while reset is asserted.
- uncache_in = !cached_port (mode 0), !(addr[31:29]==3'b100) (mode 1), or 1 (mode 2).
- CPU handshake: addr_ok = (!slot_v | bus.addr_ok) & (count < MAX_OUTSTANDING) & !order_block. No combinational path from *_req to *_addr_ok.
- order_block = (count != 0) & (uncache_in != last_uncache). This stalls a cached/uncached switch until the channel drains.
- On req & addr_ok:
  - addr, size, op, wstrb, wdata and uncache_in are captured into the slot;
  - slot_v is set next cycle;
  - last_uncache is updated;
  - count is incremented.
- Bus side:
  - bus.valid = slot_v, with all bus request fields driven from the slot;
  - slot_v clears on bus.addr_ok unless refilled in the same cycle;
  - a slot refill and bus.addr_ok in the same cycle give back-to-back issue at 1 request/cycle;
  - slot contents are stable while valid & !addr_ok.
- count tracks CPU-accepted requests not yet answered.
  - Increment on CPU handshake; decrement on bus.data_ok.
  - Simultaneous increment and decrement leave count unchanged.
  - Width is $clog2(MAX_OUTSTANDING+1).
- bus.data_ok with count==0: response suppressed (no CPU data_ok), count stays 0, proto_err set until reset. This also covers stale responses arriving after a reset mid-transaction.
- Response path:
  - RSP_REG=0: data_ok/rdata combinational from the bus;
  - RSP_REG=1: registered, 1-cycle extra latency; rdata holds its last value when data_ok=0.
- Minimum request-to-response latency is 1 cycle + cache latency (+1 if RSP_REG).
- Responses return in acceptance order; the cache guarantees in-order completion within one attribute class.

Decomposition:
- Package cc_bridge_pkg holds:
  - cache-mode localparams CC_MODE_PORT/CC_MODE_KSEG/CC_MODE_UNCACHED;
  - the kseg0 decode constant 3'b100;
  - the typedef cc_req_t {addr, size, op, wstrb, wdata, uncache}.
- Sub-module cc_bridge_chan (parameters DATA_W, MAX_OUTSTANDING, RSP_REG) implements the slot, counter, ordering and response logic. It is instantiated twice; the top level does only the cacheability decode and interface wiring.

Test Plan:
- Back-to-back cached reads at inst_addr 0x80000000, 0x80000008, cache addr_ok always 1, data_ok 3 cycles later: one issue per cycle; data_ok order matches; count peaks at 4; 5th request stalled (addr_ok=0) until first data_ok.
- Cached load 0x80001000 then uncached load 0xA0001000 (CACHE_MODE 1): data_addr_ok=0 until count==0; second request issues with dbus.uncache=1.
- Store wdata 0xDEADBEEF, wstrb 4'b0011, cache addr_ok held low 3 cycles: dbus fields stable all 3 cycles; CPU addr_ok=0 during the stall; exactly one dbus handshake.
- bus.data_ok pulse with count==0: no data_data_ok; data_proto_err=1 and stays 1 until reset.
- RSP_REG=1, inst rdata 64'h0123456789ABCDEF: inst_data_ok asserted exactly 1 cycle after ibus.data_ok with matching rdata.
- Reset asserted with 2 requests outstanding: all outputs 0 immediately; afterwards late bus data_ok is suppressed and flags proto_err.
